// File: rtl/iod_train_pkg.sv
// Shared types for the DDR4 reference-clock IOD training controller:
// FSM states, tap classification and ERR_CODE values.
package iod_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_SETTLE = 4'd2,
    ST_SAMPLE = 4'd3,
    ST_EVAL   = 4'd4,
    ST_STEP   = 4'd5,
    ST_VERIFY = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_ONE  = 2'd1,
    CLS_JIT  = 2'd2
  } cls_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NO_EDGE = 2'd1;
  localparam logic [1:0] ERR_OOR     = 2'd2;
  localparam logic [1:0] ERR_EYE     = 2'd3;

  // States in which a training run is in flight (TRAIN_BUSY high).
  function automatic logic is_busy(state_e s);
    return s inside {ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_EVAL, ST_STEP, ST_VERIFY};
  endfunction

endpackage

// File: rtl/iod_ref_clk_train_ctrl_if.sv
// Fabric-side bundle between the training controller (master) and the
// IOD lane / PHY sequencer (slave).
interface iod_ref_clk_train_ctrl_if;
  logic       TRAIN_START;
  logic [7:0] RX_DATA;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       TRAIN_BUSY;
  logic       TRAIN_DONE;
  logic       TRAIN_ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] TAP_COUNT;

  modport master (
    input  TRAIN_START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
           EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
    output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
           ERR_CODE, TAP_COUNT
  );

  modport slave (
    output TRAIN_START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
           EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
    input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
           ERR_CODE, TAP_COUNT
  );
endinterface

// File: rtl/iod_train_sample_win.sv
// Per-tap sample window: counts ones in SAMPLES consecutive RX bits after a
// start pulse and classifies the tap as stable 0, stable 1 or jitter.
module iod_train_sample_win
  import iod_train_pkg::*;
#(
  parameter int SAMPLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic bit_i,
  output logic done_o,
  output cls_e cls_o
);

  localparam int ONES_W = $clog2(SAMPLES + 1);
  localparam int IDX_W  = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SAMPLES - 1);
  localparam logic [ONES_W-1:0] ONES_FULL = ONES_W'(SAMPLES);

  logic [ONES_W-1:0] ones_q;
  logic [IDX_W-1:0]  idx_q;
  logic              active_q;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      ones_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      ones_q <= ones_q + ONES_W'(bit_i);
      idx_q  <= idx_q + 1'b1;
      if (idx_q == IDX_LAST) active_q <= 1'b0;
    end
  end

  // High during the last sample cycle; the count is final one cycle later.
  assign done_o = active_q && (idx_q == IDX_LAST);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    cls_o = CLS_JIT;
    if (ones_q == '0)            cls_o = CLS_ZERO;
    else if (ones_q == ONES_FULL) cls_o = CLS_ONE;
  end

endmodule

// File: rtl/iod_ref_clk_train_ctrl.sv
// DDR4 reference-clock IOD training controller: sweeps the input delay tap by
// tap until the first stable 0->1 transition. Optional eye-monitor check via
// `define IOD_TRAIN_EYE_MON_EN.
module iod_ref_clk_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 16
) (
  input logic                     FAB_CLK,
  input logic                     ARST_N,
  iod_ref_clk_train_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + SAMPLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       TAP_LAST    = 8'(MAX_TAPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tap_q, tap_d;
  logic             seen0_q, seen0_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             load_q, move_q, busy_q;

  logic settle_last;
  logic win_done;
  cls_e win_cls;

  assign settle_last = (state_q == ST_SETTLE) && (cnt_q == SETTLE_LAST);

  iod_train_sample_win #(.SAMPLES(SAMPLES)) u_win (
    .clk     (FAB_CLK),
    .rst_n   (ARST_N),
    .start_i (settle_last),
    .bit_i   (bus.RX_DATA[0]),
    .done_o  (win_done),
    .cls_o   (win_cls)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    seen0_d = seen0_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.TRAIN_START) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          tap_d   = '0;
          seen0_d = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (settle_last) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q + 1'b1;
      end
      ST_SAMPLE: begin
        if (win_done) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (win_cls == CLS_ZERO) seen0_d = 1'b1;
        // A stable 1 only counts once a stable 0 has been seen at an earlier tap.
        if (seen0_q && (win_cls == CLS_ONE)) begin
`ifdef IOD_TRAIN_EYE_MON_EN
          state_d = ST_VERIFY;
          cnt_d   = '0;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else if (tap_q == TAP_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_NO_EDGE;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        tap_d   = tap_q + 1'b1;
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
`ifdef IOD_TRAIN_EYE_MON_EN
      ST_VERIFY: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES + SAMPLES)) begin
          if (bus.EYE_MONITOR_EARLY && bus.EYE_MONITOR_LATE) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_EYE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Overflow of the delay line wins over any outcome decided above.
    if (is_busy(state_q) && bus.DELAY_LINE_OUT_OF_RANGE) begin
      state_d = ST_ERR;
      done_d  = 1'b0;
      err_d   = 1'b1;
      code_d  = ERR_OOR;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tap_q   <= '0;
      seen0_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      seen0_q <= seen0_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      load_q  <= (state_d == ST_LOAD);
      move_q  <= (state_d == ST_STEP);
      busy_q  <= is_busy(state_d);
    end
  end

`ifdef IOD_TRAIN_EYE_MON_EN
  logic clear_q;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) clear_q <= 1'b0;
    else         clear_q <= (state_d == ST_VERIFY) && (state_q != ST_VERIFY);
  end

  assign bus.EYE_MONITOR_CLEAR_FLAGS = clear_q;
`else
  logic unused_eye;
  assign unused_eye                  = bus.EYE_MONITOR_EARLY ^ bus.EYE_MONITOR_LATE;
  assign bus.EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

  // Only bit 0 of the deserialised word is classified.
  logic unused_rx;
  assign unused_rx = ^bus.RX_DATA[7:1];

  assign bus.DELAY_LINE_LOAD      = load_q;
  assign bus.DELAY_LINE_MOVE      = move_q;
  assign bus.DELAY_LINE_DIRECTION = move_q;
  assign bus.TRAIN_BUSY           = busy_q;
  assign bus.TRAIN_DONE           = done_q;
  assign bus.TRAIN_ERR            = err_q;
  assign bus.ERR_CODE             = code_q;
  assign bus.TAP_COUNT            = tap_q;

endmodule
